// File: rtl/pid_controller_if.sv
// Error-sample / control-output bundle of pid_controller.
// master: error-computation side (drives e_in, observes u_out).
// slave:  the PID controller itself (consumes e_in, drives u_out).
interface pid_controller_if;
    logic signed [15:0] e_in;
    logic signed [15:0] u_out;

    modport master (output e_in, input  u_out);
    modport slave  (input  e_in, output u_out);
endinterface

// File: rtl/pid_controller.sv
// Discrete-time PID controller, two-stage datapath, one update per clock.
//   Stage 1: e1 <= e_in, e2 <= e1, acc <= sat(acc + e_in)
//   Stage 2: u_out <= sat16((KP*e1 + KI*acc + KD*(e1-e2)) >>> SHIFT)
// Stage 2 reads the pre-edge stage-1 registers, so a sample reaches
// u_out one edge after it is captured.
// Optional feature: define PID_ANTIWINDUP_EN to clamp the integrator
// to [-INT_LIM, +INT_LIM] on every update.
module pid_controller #(
    parameter logic signed [15:0] KP      = 16'sd2,
    parameter logic signed [15:0] KI      = 16'sd1,
    parameter logic signed [15:0] KD      = 16'sd1,
    parameter int                 SHIFT   = 0,
    parameter int                 ACC_W   = 32,
    parameter int                 INT_LIM = 1000
) (
    input  logic             clk,
    input  logic             reset,
    pid_controller_if.slave  bus
);

    // Sum width: ACC_W+16 for the integral product plus headroom for the
    // three-term sum; never truncates a legal result.
    localparam int SW = ACC_W + 34;

`ifdef PID_ANTIWINDUP_EN
    localparam bit AW_EN = 1'b1;
`else
    localparam bit AW_EN = 1'b0;
`endif

    localparam logic signed [ACC_W:0]   ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0]   ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};
    localparam logic signed [SW-1:0]    U_MAX   = {{(SW-16){1'b0}}, 16'sh7FFF};
    localparam logic signed [SW-1:0]    U_MIN   = {{(SW-16){1'b1}}, 16'sh8000};
    localparam logic signed [63:0]      LIM_P64 = 64'(INT_LIM);
    localparam logic signed [63:0]      LIM_N64 = -LIM_P64;
    localparam logic signed [ACC_W-1:0] LIM_HI  = LIM_P64[ACC_W-1:0];
    localparam logic signed [ACC_W-1:0] LIM_LO  = LIM_N64[ACC_W-1:0];

    // Clamp the one-bit-wider accumulator sum back into ACC_W signed range.
    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] v);
        if (v > ACC_MAX) begin
            sat_acc = ACC_MAX[ACC_W-1:0];
        end else if (v < ACC_MIN) begin
            sat_acc = ACC_MIN[ACC_W-1:0];
        end else begin
            sat_acc = v[ACC_W-1:0];
        end
    endfunction

    // Clamp the scaled control sum to the 16-bit output range.
    function automatic logic signed [15:0] sat16(input logic signed [SW-1:0] v);
        if (v > U_MAX) begin
            sat16 = 16'sh7FFF;
        end else if (v < U_MIN) begin
            sat16 = 16'sh8000;
        end else begin
            sat16 = v[15:0];
        end
    endfunction

    logic signed [15:0]      e1_q,  e1_d;
    logic signed [15:0]      e2_q,  e2_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [15:0]      u_out_q, u_out_d;

    logic signed [ACC_W:0]   acc_sum_s;
    logic signed [ACC_W-1:0] acc_sat_s;
    logic signed [63:0]      acc_w64_s;
    logic signed [16:0]      diff_s;
    logic signed [SW-1:0]    kp_x_s, ki_x_s, kd_x_s;
    logic signed [SW-1:0]    e1_x_s, acc_x_s, diff_x_s;
    logic signed [SW-1:0]    sum_s, sum_sh_s;

    // Next-state computation for both pipeline stages.
    always_comb begin
        // Stage 1: delay line and saturating integrator.
        e1_d      = bus.e_in;
        e2_d      = e1_q;
        acc_sum_s = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-15){bus.e_in[15]}}, bus.e_in};
        acc_sat_s = sat_acc(acc_sum_s);
        acc_w64_s = {{(64-ACC_W){acc_sat_s[ACC_W-1]}}, acc_sat_s};
        acc_d     = acc_sat_s;
        if (AW_EN) begin
            if (acc_w64_s > LIM_P64) begin
                acc_d = LIM_HI;
            end else if (acc_w64_s < LIM_N64) begin
                acc_d = LIM_LO;
            end else begin
                acc_d = acc_sat_s;
            end
        end else begin
            acc_d = acc_sat_s;
        end

        // Stage 2: full-precision PID sum from pre-edge registers.
        diff_s   = {e1_q[15], e1_q} - {e2_q[15], e2_q};
        kp_x_s   = {{(SW-16){KP[15]}}, KP};
        ki_x_s   = {{(SW-16){KI[15]}}, KI};
        kd_x_s   = {{(SW-16){KD[15]}}, KD};
        e1_x_s   = {{(SW-16){e1_q[15]}}, e1_q};
        acc_x_s  = {{(SW-ACC_W){acc_q[ACC_W-1]}}, acc_q};
        diff_x_s = {{(SW-17){diff_s[16]}}, diff_s};
        sum_s    = (kp_x_s * e1_x_s) + (ki_x_s * acc_x_s) + (kd_x_s * diff_x_s);
        sum_sh_s = sum_s >>> SHIFT;
        u_out_d  = sat16(sum_sh_s);
    end

    // Pipeline registers; reset clears all state immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e1_q    <= '0;
            e2_q    <= '0;
            acc_q   <= '0;
            u_out_q <= '0;
        end else begin
            e1_q    <= e1_d;
            e2_q    <= e2_d;
            acc_q   <= acc_d;
            u_out_q <= u_out_d;
        end
    end

    assign bus.u_out = u_out_q;

endmodule

// File: tb/tb_pid_controller.sv
// Directed self-checking bench for pid_controller. Several parameterised
// instances share clk/reset; each phase drives one of them.
module tb_pid_controller;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pid_controller_if if_def ();
    pid_controller_if if_p   ();
    pid_controller_if if_d   ();
    pid_controller_if if_big ();
    pid_controller_if if_i   ();
    pid_controller_if if_sat ();

    pid_controller u_def (.clk(clk), .reset(reset), .bus(if_def));
    pid_controller #(.KP(16'sd1), .KI(16'sd0), .KD(16'sd0))
        u_p (.clk(clk), .reset(reset), .bus(if_p));
    pid_controller #(.KP(16'sd0), .KI(16'sd0), .KD(16'sd1))
        u_d (.clk(clk), .reset(reset), .bus(if_d));
    pid_controller #(.KP(16'sd1000), .KI(16'sd0), .KD(16'sd0))
        u_big (.clk(clk), .reset(reset), .bus(if_big));
    pid_controller #(.KP(16'sd0), .KI(16'sd1), .KD(16'sd0))
        u_i (.clk(clk), .reset(reset), .bus(if_i));
    pid_controller #(.KP(16'sd0), .KI(16'sd1), .KD(16'sd0), .SHIFT(2), .ACC_W(18), .INT_LIM(200000))
        u_sat (.clk(clk), .reset(reset), .bus(if_sat));

    task automatic check_val(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One rising edge, then step 1 time unit away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        if_def.e_in = 16'sd0; if_p.e_in = 16'sd0; if_d.e_in = 16'sd0;
        if_big.e_in = 16'sd0; if_i.e_in = 16'sd0; if_sat.e_in = 16'sd0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    int exp_a;
    int exp_b;
    int exp_c;
    int sat_exp [7];

    initial begin
        // Reset holds output at zero despite a live input.
        do_reset();
        reset = 1'b1;
        if_def.e_in = 16'sd1234;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("reset_hold", if_def.u_out, 0);
        end

        // Constant unit error with default gains: 0,4,4,5,6.
        if_def.e_in = 16'sd1;
        reset = 1'b0;
        tick(); check_val("def_e1", if_def.u_out, 0);
        tick(); check_val("def_e2", if_def.u_out, 4);
        tick(); check_val("def_e3", if_def.u_out, 4);
        tick(); check_val("def_e4", if_def.u_out, 5);
        tick(); check_val("def_e5", if_def.u_out, 6);

        // Asynchronous reset clears output between edges.
        #2;
        reset = 1'b1;
        #1;
        check_val("async_clr", if_def.u_out, 0);

        // Pure proportional path, two-edge latency.
        do_reset();
        if_p.e_in = -16'sd7;
        tick(); check_val("p_lat", if_p.u_out, 0);
        if_p.e_in = 16'sd9;
        tick(); check_val("p_neg", if_p.u_out, -7);
        tick(); check_val("p_pos", if_p.u_out, 9);

        // Pure derivative: step produces a one-cycle pulse.
        do_reset();
        tick(); tick();
        if_d.e_in = 16'sd100;
        tick(); check_val("d_pre",   if_d.u_out, 0);
        tick(); check_val("d_pulse", if_d.u_out, 100);
        tick(); check_val("d_after", if_d.u_out, 0);
        tick(); check_val("d_hold",  if_d.u_out, 0);

        // Output saturation in both directions.
        do_reset();
        if_big.e_in = 16'sd100;
        tick(); tick();
        check_val("sat_pos", if_big.u_out, 32767);
        if_big.e_in = -16'sd100;
        tick(); tick();
        check_val("sat_neg", if_big.u_out, -32768);

        // Integrator ramp and (optional) anti-windup clamp.
`ifdef PID_ANTIWINDUP_EN
        exp_a = 1000; exp_b = 1000; exp_c = 900;
`else
        exp_a = 1900; exp_b = 2000; exp_c = 1900;
`endif
        do_reset();
        if_i.e_in = 16'sd100;
        for (int k = 0; k < 20; k++) tick();
        check_val("int_ramp", if_i.u_out, exp_a);
        if_i.e_in = -16'sd100;
        tick(); check_val("int_peak", if_i.u_out, exp_b);
        tick(); check_val("int_down", if_i.u_out, exp_c);

        // Accumulator saturates at its negative limit instead of wrapping.
        sat_exp = '{0, -8192, -16384, -24576, -32768, -32768, -32768};
        do_reset();
        if_sat.e_in = -16'sd32768;
        for (int k = 0; k < 7; k++) begin
            tick();
            check_val($sformatf("acc_sat_%0d", k + 1), if_sat.u_out, sat_exp[k]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
